output_stage_fifo: RTL and testbench
====================================

Name: output_stage_fifo

Overview:
Parametrised successor to the single-register output stage of the transceiver datapath. It decodes each accepted op (RXA/TXE) into host-bound and network-bound words using the same steering rules, and queues them in two independent FWFT FIFOs. Single-cycle ready pulses become valid/ready handshakes with backpressure. It sits between the tag-compare/parity stage and the host and network interfaces.

Parameters:
data_size, 32, width of host data words
tag_size, 8, width of tag; network words are data_size+tag_size bits
depth, 4, entries per FIFO; power of two, minimum 2

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
in_valid_in  in  1  upstream op valid
in_ready_out  out  1  stage can accept an op this cycle
opcode_in  in  2  2'b10=RXA, 2'b01=TXE, others=no-op
soft_error_in  in  1  parity error on this op
tx_data_in  in  data_size  transmit data
tx_data_plus_tag_in  in  data_size+tag_size  transmit data with tag
tag_match_in  in  1  received tag matches the outstanding tag
rx_data_in  in  data_size  received data
ndt_in  in  data_size+tag_size  network data+tag pass-through
host_ready_in  in  1  host consumes the head word
host_valid_out  out  1  host FIFO non-empty
host_data_out  out  data_size  host FIFO head
network_ready_in  in  1  network consumes the head word
network_valid_out  out  1  network FIFO non-empty
ndt_out  out  data_size+tag_size  network FIFO head
network_ack_out  out  1  one-cycle ack pulse
parity_error_out  out  1  one-cycle error pulse
host_count_out  out  $clog2(depth)+1  host FIFO occupancy
net_count_out  out  $clog2(depth)+1  network FIFO occupancy
err_count_out  out  16  error counter (see Optional Feature)

Behaviour:
- Reset: all outputs 0, both FIFOs empty, pointers 0. in_ready_out is 1 in the first cycle after reset. Reset mid-operation discards queued words.
- Clock and reset: single clock domain, clk. Reset is synchronous and active-high on port reset.
- in_ready_out = (host_count_out < depth) && (net_count_out < depth). This is combinational from registered counts. There is no push-through-pop when full.
- Accept: acc = in_valid_in && in_ready_out. Decode uses the current-cycle inputs:
  - ack_c = tag_match_in && opcode==RXA
  - host_push = acc && (soft_error_in || ack_c)
  - host word = (soft_error_in || ack_c) ? tx_data_in : rx_data_in
  - net_push = acc && (ack_c || (!soft_error_in && opcode==TXE))
  - net word = (ack_c || opcode==RXA) ? tx_data_plus_tag_in : ndt_in
- An accepted op with neither push is consumed silently.
- network_ack_out is registered as acc && ack_c: a 1-cycle pulse one cycle after accept.
- parity_error_out is registered as acc && soft_error_in: a 1-cycle pulse one cycle after accept.
- FIFOs:
  - First-word fall-through; valid = count != 0; data = mem[rd_ptr].
  - Pop = valid && ready. Push-to-output latency is 1 cycle.
  - Simultaneous push and pop leaves count unchanged; allowed at any non-full count, including count 1.
  - Pointers are log2(depth) bits and wrap naturally.
  - Head data holds stable while valid && !ready.
  - Data outputs are don't-care when valid=0 but must not be X after reset (mem reset to 0).
- in_valid_in when in_ready_out=0 is ignored, with no side effects.

Optional Feature:
Macro OUTPUT_STAGE_ERR_CNT_EN.
- Defined: err_count_out is a 16-bit saturating counter. It increments on each acc && soft_error_in and holds at 16'hFFFF. Reset clears it.
- Undefined: no counter logic is built and err_count_out is tied to 16'h0000.

Test Plan:
- Reset, then RXA with tag_match=1, tx_data=32'hDEADBEEF, tx_data_plus_tag=40'h11DEADBEEF → next cycle network_ack_out=1 for one cycle; host_data_out=DEADBEEF; ndt_out=11DEADBEEF; both valid, counts=1.
- TXE, soft_error=0, ndt_in=40'hAA12345678 → net FIFO only, ndt_out=AA12345678; host_valid_out stays 0; no ack.
- TXE with soft_error=1, tx_data=32'h0BADF00D → parity_error_out pulse; host_data_out=0BADF00D; no network push; err_count_out=1 (macro on) or 0 (off).
- host_ready=0, issue 4 error ops with tx_data 1,2,3,4 → host_count=4, in_ready_out=0; a 5th op is ignored. Raise host_ready → data pops in order 1,2,3,4 with pointer wrap; in_ready_out returns to 1 after the first pop.
- Continuous TXE ops with network_ready=1 → sustained push and pop each cycle, net_count stays 1, no lost words over 20 ops with incrementing data.
- Fill host FIFO to 2, assert reset for 1 cycle → all counts, valids and pulses are 0 next cycle; in_ready_out=1.

Source files
------------

// File: rtl/output_stage_fifo.sv
// output_stage_fifo: decodes accepted RXA/TXE ops into host-bound and
// network-bound words and queues each stream in its own first-word
// fall-through FIFO with valid/ready handshakes on both outputs.
// Optional build macro OUTPUT_STAGE_ERR_CNT_EN adds a 16-bit saturating
// parity-error counter on err_count_out; without it the port is tied to 0.

module output_stage_fifo_buf #(
    parameter int width = 32,
    parameter int depth = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [width-1:0]         push_data,
    input  logic                     pop_ready,
    output logic                     valid,
    output logic [width-1:0]         head,
    output logic [$clog2(depth):0]   count
);
    localparam int AW = $clog2(depth);
    localparam int CW = AW + 1;

    logic [width-1:0] mem [depth];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt;
    logic             pop;

    // Head word falls through from the read pointer; pop only when something is there.
    always_comb begin
        valid = (cnt != '0);
        head  = mem[rd_ptr];
        count = cnt;
        pop   = valid && pop_ready;
    end

    // Storage, pointers and occupancy; mem is cleared so the head is never X.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            for (int i = 0; i < depth; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end
endmodule

module output_stage_fifo #(
    parameter int data_size = 32,
    parameter int tag_size  = 8,
    parameter int depth     = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_valid_in,
    output logic                          in_ready_out,
    input  logic [1:0]                    opcode_in,
    input  logic                          soft_error_in,
    input  logic [data_size-1:0]          tx_data_in,
    input  logic [data_size+tag_size-1:0] tx_data_plus_tag_in,
    input  logic                          tag_match_in,
    input  logic [data_size-1:0]          rx_data_in,
    input  logic [data_size+tag_size-1:0] ndt_in,
    input  logic                          host_ready_in,
    output logic                          host_valid_out,
    output logic [data_size-1:0]          host_data_out,
    input  logic                          network_ready_in,
    output logic                          network_valid_out,
    output logic [data_size+tag_size-1:0] ndt_out,
    output logic                          network_ack_out,
    output logic                          parity_error_out,
    output logic [$clog2(depth):0]        host_count_out,
    output logic [$clog2(depth):0]        net_count_out,
    output logic [15:0]                   err_count_out
);
    localparam int CW = $clog2(depth) + 1;
    localparam int NW = data_size + tag_size;
    localparam logic [CW-1:0] FULL = CW'(depth);
    localparam logic [1:0] OP_RXA = 2'b10;
    localparam logic [1:0] OP_TXE = 2'b01;

    logic                 acc_p0;
    logic                 ack_c_p0;
    logic                 host_push_p0;
    logic                 net_push_p0;
    logic [data_size-1:0] host_word_p0;
    logic [NW-1:0]        net_word_p0;
    logic                 ack_p1;
    logic                 perr_p1;

    // Accept gating and op decode into the two output streams.
    always_comb begin
        in_ready_out = (host_count_out < FULL) && (net_count_out < FULL);
        acc_p0       = in_valid_in && in_ready_out;
        ack_c_p0     = tag_match_in && (opcode_in == OP_RXA);
        host_push_p0 = acc_p0 && (soft_error_in || ack_c_p0);
        host_word_p0 = (soft_error_in || ack_c_p0) ? tx_data_in : rx_data_in;
        net_push_p0  = acc_p0 && (ack_c_p0 || (!soft_error_in && (opcode_in == OP_TXE)));
        net_word_p0  = (ack_c_p0 || (opcode_in == OP_RXA)) ? tx_data_plus_tag_in : ndt_in;
    end

    output_stage_fifo_buf #(.width(data_size), .depth(depth)) u_host_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (host_push_p0),
        .push_data (host_word_p0),
        .pop_ready (host_ready_in),
        .valid     (host_valid_out),
        .head      (host_data_out),
        .count     (host_count_out)
    );

    output_stage_fifo_buf #(.width(NW), .depth(depth)) u_net_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (net_push_p0),
        .push_data (net_word_p0),
        .pop_ready (network_ready_in),
        .valid     (network_valid_out),
        .head      (ndt_out),
        .count     (net_count_out)
    );

    // One-cycle ack and parity-error pulses registered after the accept cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            ack_p1  <= 1'b0;
            perr_p1 <= 1'b0;
        end else begin
            ack_p1  <= acc_p0 && ack_c_p0;
            perr_p1 <= acc_p0 && soft_error_in;
        end
    end

    assign network_ack_out  = ack_p1;
    assign parity_error_out = perr_p1;

`ifdef OUTPUT_STAGE_ERR_CNT_EN
    logic [15:0] err_cnt_p1;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Saturating count of accepted ops that carried a parity error.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_cnt_p1 <= 16'h0000;
        end else if (acc_p0 && soft_error_in) begin
            err_cnt_p1 <= sat_inc16(err_cnt_p1);
        end
    end

    assign err_count_out = err_cnt_p1;
`else
    assign err_count_out = 16'h0000;
`endif
endmodule

// File: tb/tb_output_stage_fifo.sv
// Bench for output_stage_fifo: a queue-based model of the two output streams
// is compared with the DUT every cycle, plus directed literal expectations.
module tb_output_stage_fifo;
    localparam int DS = 32;
    localparam int TS = 8;
    localparam int DP = 4;
    localparam int CW = $clog2(DP) + 1;

    logic            clk = 0;
    logic            reset = 1;
    logic            in_valid_in = 0;
    logic            in_ready_out;
    logic [1:0]      opcode_in = 0;
    logic            soft_error_in = 0;
    logic [DS-1:0]   tx_data_in = 0;
    logic [DS+TS-1:0] tx_data_plus_tag_in = 0;
    logic            tag_match_in = 0;
    logic [DS-1:0]   rx_data_in = 0;
    logic [DS+TS-1:0] ndt_in = 0;
    logic            host_ready_in = 0;
    logic            host_valid_out;
    logic [DS-1:0]   host_data_out;
    logic            network_ready_in = 0;
    logic            network_valid_out;
    logic [DS+TS-1:0] ndt_out;
    logic            network_ack_out;
    logic            parity_error_out;
    logic [CW-1:0]   host_count_out;
    logic [CW-1:0]   net_count_out;
    logic [15:0]     err_count_out;

    output_stage_fifo #(.data_size(DS), .tag_size(TS), .depth(DP)) dut (
        .clk(clk), .reset(reset), .in_valid_in(in_valid_in), .in_ready_out(in_ready_out),
        .opcode_in(opcode_in), .soft_error_in(soft_error_in), .tx_data_in(tx_data_in),
        .tx_data_plus_tag_in(tx_data_plus_tag_in), .tag_match_in(tag_match_in),
        .rx_data_in(rx_data_in), .ndt_in(ndt_in), .host_ready_in(host_ready_in),
        .host_valid_out(host_valid_out), .host_data_out(host_data_out),
        .network_ready_in(network_ready_in), .network_valid_out(network_valid_out),
        .ndt_out(ndt_out), .network_ack_out(network_ack_out),
        .parity_error_out(parity_error_out), .host_count_out(host_count_out),
        .net_count_out(net_count_out), .err_count_out(err_count_out)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;
    bit chk_en = 0;

    // Behavioural model: two queues plus the registered pulses and counter.
    logic [DS-1:0]    hq[$];
    logic [DS+TS-1:0] nq[$];
    logic             m_ack = 0, m_perr = 0;
    int               m_ec = 0;

    always @(posedge clk) begin
        if (reset) begin
            hq.delete(); nq.delete();
            m_ack = 0; m_perr = 0; m_ec = 0;
        end else begin
            bit rdy, acc, ackc, err;
            rdy  = (hq.size() < DP) && (nq.size() < DP);
            acc  = in_valid_in && rdy;
            ackc = tag_match_in && (opcode_in == 2'b10);
            err  = soft_error_in;
            if (hq.size() > 0 && host_ready_in) void'(hq.pop_front());
            if (nq.size() > 0 && network_ready_in) void'(nq.pop_front());
            if (acc && (err || ackc)) hq.push_back(tx_data_in);
            else if (acc) begin end
            if (acc && ackc) nq.push_back(tx_data_plus_tag_in);
            else if (acc && !err && opcode_in == 2'b01) nq.push_back(ndt_in);
            m_ack  = acc && ackc;
            m_perr = acc && err;
`ifdef OUTPUT_STAGE_ERR_CNT_EN
            if (acc && err && m_ec < 65535) m_ec = m_ec + 1;
`endif
        end
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("m_in_ready", 64'(in_ready_out), 64'((hq.size() < DP) && (nq.size() < DP)));
            check("m_host_valid", 64'(host_valid_out), 64'(hq.size() != 0));
            check("m_net_valid", 64'(network_valid_out), 64'(nq.size() != 0));
            check("m_host_count", 64'(host_count_out), 64'(hq.size()));
            check("m_net_count", 64'(net_count_out), 64'(nq.size()));
            check("m_ack", 64'(network_ack_out), 64'(m_ack));
            check("m_perr", 64'(parity_error_out), 64'(m_perr));
            check("m_err_count", 64'(err_count_out), 64'(m_ec));
            if (hq.size() != 0) check("m_host_data", 64'(host_data_out), 64'(hq[0]));
            else check("m_host_data_known", 64'(!$isunknown(host_data_out)), 64'(1));
            if (nq.size() != 0) check("m_ndt", 64'(ndt_out), 64'(nq[0]));
            else check("m_ndt_known", 64'(!$isunknown(ndt_out)), 64'(1));
        end
    end

    task automatic op(input logic [1:0] opc, input logic se, input logic tm,
                      input logic [DS-1:0] tx, input logic [DS+TS-1:0] txt,
                      input logic [DS+TS-1:0] ndt);
        @(posedge clk); #1;
        in_valid_in = 1; opcode_in = opc; soft_error_in = se; tag_match_in = tm;
        tx_data_in = tx; tx_data_plus_tag_in = txt; rx_data_in = 32'hCAFE0000 | tx; ndt_in = ndt;
    endtask

    task automatic idle();
        @(posedge clk); #1;
        in_valid_in = 0; opcode_in = 0; soft_error_in = 0; tag_match_in = 0;
    endtask

    int exp_ec;

    initial begin
        exp_ec = 0;
        repeat (3) @(posedge clk);
        #1 reset = 0; chk_en = 1;
        check("rst_in_ready", 64'(in_ready_out), 64'(1));
        check("rst_host_valid", 64'(host_valid_out), 64'(0));
        check("rst_host_count", 64'(host_count_out), 64'(0));
        check("rst_net_count", 64'(net_count_out), 64'(0));
        check("rst_host_data", 64'(host_data_out), 64'(0));

        // RXA with tag match: both streams, ack pulse.
        op(2'b10, 0, 1, 32'hDEADBEEF, 40'h11DEADBEEF, 40'h0);
        idle();
        check("rxa_ack", 64'(network_ack_out), 64'(1));
        check("rxa_host_data", 64'(host_data_out), 64'h00000000DEADBEEF);
        check("rxa_ndt", 64'(ndt_out), 64'h00000011DEADBEEF);
        check("rxa_host_count", 64'(host_count_out), 64'(1));
        check("rxa_net_count", 64'(net_count_out), 64'(1));
        idle();
        check("rxa_ack_gone", 64'(network_ack_out), 64'(0));
        host_ready_in = 1; network_ready_in = 1;
        idle(); idle();
        host_ready_in = 0; network_ready_in = 0;

        // TXE without error: network only.
        op(2'b01, 0, 0, 32'h1, 40'h0, 40'hAA12345678);
        idle();
        check("txe_net_valid", 64'(network_valid_out), 64'(1));
        check("txe_ndt", 64'(ndt_out), 64'h000000AA12345678);
        check("txe_host_valid", 64'(host_valid_out), 64'(0));
        check("txe_ack", 64'(network_ack_out), 64'(0));
        network_ready_in = 1; idle(); network_ready_in = 0;

        // TXE with parity error: host only, error pulse.
        op(2'b01, 1, 0, 32'h0BADF00D, 40'h0, 40'h55);
        idle();
`ifdef OUTPUT_STAGE_ERR_CNT_EN
        exp_ec = 1;
`endif
        check("err_pulse", 64'(parity_error_out), 64'(1));
        check("err_host_data", 64'(host_data_out), 64'h000000000BADF00D);
        check("err_net_count", 64'(net_count_out), 64'(0));
        check("err_count", 64'(err_count_out), 64'(exp_ec));
        host_ready_in = 1; idle(); host_ready_in = 0;

        // Fill host FIFO, then a 5th op must be ignored.
        for (int i = 1; i <= 4; i++) op(2'b01, 1, 0, DS'(i), 40'h0, 40'h0);
        idle();
        check("full_host_count", 64'(host_count_out), 64'(4));
        check("full_in_ready", 64'(in_ready_out), 64'(0));
        op(2'b01, 1, 0, 32'h5, 40'h0, 40'h0);
        idle();
        check("full_ignored", 64'(host_count_out), 64'(4));
`ifdef OUTPUT_STAGE_ERR_CNT_EN
        exp_ec = 5;
`endif
        check("full_err_count", 64'(err_count_out), 64'(exp_ec));
        host_ready_in = 1;
        for (int i = 1; i <= 4; i++) begin
            check("drain_order", 64'(host_data_out), 64'(i));
            idle();
            if (i == 1) check("drain_ready_back", 64'(in_ready_out), 64'(1));
        end
        check("drain_empty", 64'(host_valid_out), 64'(0));
        host_ready_in = 0;

        // Streaming TXE with the network always ready.
        network_ready_in = 1;
        for (int i = 0; i < 20; i++) begin
            op(2'b01, 0, 0, 32'h0, 40'h0, 40'h3300000000 + 40'(i));
            if (i > 0) begin
                check("stream_count", 64'(net_count_out), 64'(1));
                check("stream_data", 64'(ndt_out), 64'(40'h3300000000 + 40'(i - 1)));
            end
        end
        idle(); idle();
        check("stream_drained", 64'(net_count_out), 64'(0));
        network_ready_in = 0;

        // Reset mid-operation discards queued words.
        op(2'b01, 1, 0, 32'hA1, 40'h0, 40'h0);
        op(2'b01, 1, 0, 32'hA2, 40'h0, 40'h0);
        idle();
        check("pre_rst_count", 64'(host_count_out), 64'(2));
        reset = 1;
        idle();
        reset = 0;
        check("rst2_host_count", 64'(host_count_out), 64'(0));
        check("rst2_host_valid", 64'(host_valid_out), 64'(0));
        check("rst2_perr", 64'(parity_error_out), 64'(0));
        check("rst2_in_ready", 64'(in_ready_out), 64'(1));
        check("rst2_err_count", 64'(err_count_out), 64'(0));
        idle(); idle();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
